// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
//   Walks a 4-bit select through all sixteen addresses of a downstream
//   4-to-16 decoder. Each address is held for dwell+1 cycles. The walk is
//   ascending (0..15) or descending (15..0). Direction and dwell are captured
//   when the scan starts, so later changes on those inputs do not affect it.
//
//   Optional feature macro: SCAN_WRAP_EN
//     undefined (default): a single pass, which ends with a one-cycle done
//                          pulse.
//     defined            : the sequence wraps around endlessly and never
//                          pulses done. Only stop or rst end the scan.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request a scan (sampled in IDLE only)
//   stop   in   abort the scan (sampled in SCAN only)
//   down   in   0 = ascending, 1 = descending (sampled with start)
//   dwell  in   extra hold cycles per address (sampled with start)
//   w      out  registered decoder select
//   En     out  registered decoder enable
//   busy   out  high while scanning
//   done   out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               down,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         w,
  output logic               En,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [3:0]         r_w;
  logic               r_en;
  logic               r_busy;
  logic               r_done;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_down;

  state_t             w_state_nxt;
  logic [3:0]         w_w_nxt;
  logic               w_en_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic               w_down_nxt;

  logic               w_hold_done;
  logic               w_last;
  logic [3:0]         w_step;

  assign w_hold_done = (r_cnt == CNT_ZERO);
  assign w_last      = r_down ? (r_w == 4'd0) : (r_w == 4'd15);
  // Modulo-16 arithmetic gives the 15->0 / 0->15 wrap for free.
  assign w_step      = r_down ? (r_w - 4'd1) : (r_w + 4'd1);

  // State register plus the registered outputs and scan context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_w     <= 4'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= CNT_ZERO;
      r_dwell <= CNT_ZERO;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwell <= w_dwell_nxt;
      r_down  <= w_down_nxt;
    end
  end

  // Next-state logic. stop outranks stepping. start outranks stop in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_hold_done && w_last) begin
`ifdef SCAN_WRAP_EN
          w_state_nxt = S_SCAN;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs. They are keyed on the state
  // being entered, so every output is a flop with no combinational path.
  always_comb begin
    w_w_nxt     = 4'd0;
    w_en_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = CNT_ZERO;
    w_dwell_nxt = r_dwell;
    w_down_nxt  = r_down;
    case (w_state_nxt)
      S_SCAN: begin
        w_en_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        if (r_state == S_IDLE) begin
          // Capture the scan context and present the first address.
          w_dwell_nxt = dwell;
          w_down_nxt  = down;
          w_cnt_nxt   = dwell;
          w_w_nxt     = down ? 4'd15 : 4'd0;
        end else if (w_hold_done) begin
          w_w_nxt   = w_step;
          w_cnt_nxt = r_dwell;
        end else begin
          w_w_nxt   = r_w;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      S_IDLE: begin
        w_done_nxt = 1'b0;
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  assign w    = r_w;
  assign En   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
//   Directed self-checking bench for scan_sequencer. Inputs are driven 1 ns
//   after each rising edge. Outputs are compared at that same point, as the
//   packed vector {En, busy, done, w}.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       down;
  logic [3:0] dwell;
  logic [3:0] w;
  logic       En;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  logic [6:0] exp_v;

  scan_sequencer #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .down  (down),
    .dwell (dwell),
    .w     (w),
    .En    (En),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; down = 1'b0; dwell = 4'd0;
    #3;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  task automatic test_up_dwell0();
    start = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'b110, 4'(i)};
      checks++;
      if ({En, busy, done, w} !== exp_v) begin
        errors++;
        $display("FAIL up_step%0d: got %b expected %b", i, {En, busy, done, w}, exp_v);
      end
      tick();
    end
    exp_v = 7'b001_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL up_done: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    tick();
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL up_idle: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  task automatic test_down_dwell2();
    start = 1'b1; down = 1'b1; dwell = 4'd2;
    tick();
    // The scan must keep the direction and dwell it captured at start.
    start = 1'b0; down = 1'b0; dwell = 4'd0;
    for (int a = 15; a >= 0; a--) begin
      for (int h = 0; h < 3; h++) begin
        exp_v = {3'b110, 4'(a)};
        checks++;
        if ({En, busy, done, w} !== exp_v) begin
          errors++;
          $display("FAIL down_addr%0d_hold%0d: got %b expected %b", a, h, {En, busy, done, w}, exp_v);
        end
        tick();
      end
    end
    exp_v = 7'b001_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL down_done: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    tick();
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL down_idle: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  task automatic test_stop();
    start = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    exp_v = 7'b110_0101;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL stop_at5: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL stop_idle: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({En, busy, done, w} !== exp_v) begin
        errors++;
        $display("FAIL stop_quiet%0d: got %b expected %b", i, {En, busy, done, w}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    exp_v = 7'b110_1001;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL rst_at9: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL rst_async_clear: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({En, busy, done, w} !== exp_v) begin
        errors++;
        $display("FAIL rst_wait_idle%0d: got %b expected %b", i, {En, busy, done, w}, exp_v);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = 7'b110_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL rst_restart: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_ignore_start();
    start = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; dwell = 4'd3;
    tick();
    exp_v = 7'b110_0100;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL midscan_start_w4: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    start = 1'b0;
    for (int i = 5; i < 16; i++) begin
      tick();
      exp_v = {3'b110, 4'(i)};
      checks++;
      if ({En, busy, done, w} !== exp_v) begin
        errors++;
        $display("FAIL midscan_w%0d: got %b expected %b", i, {En, busy, done, w}, exp_v);
      end
    end
    tick();
    exp_v = 7'b001_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL midscan_done: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    // start during DONE must not re-launch a scan.
    start = 1'b1;
    tick();
    start = 1'b0; dwell = 4'd0;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL start_in_done: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    tick();
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL idle_after_done: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    exp_v = 7'b110_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL start_stop_begin: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    tick();
    exp_v = 7'b110_0001;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL start_stop_step: got %b expected %b", {En, busy, done, w}, exp_v);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL start_stop_end: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  task automatic test_wrap();
    start = 1'b1; down = 1'b0; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_v = {3'b110, 4'(i % 16)};
      checks++;
      if ({En, busy, done, w} !== exp_v) begin
        errors++;
        $display("FAIL wrap_step%0d: got %b expected %b", i, {En, busy, done, w}, exp_v);
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_v = 7'b000_0000;
    checks++;
    if ({En, busy, done, w} !== exp_v) begin
      errors++;
      $display("FAIL wrap_stop: got %b expected %b", {En, busy, done, w}, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef SCAN_WRAP_EN
    test_wrap();
`else
    test_up_dwell0();
    test_down_dwell2();
    test_stop();
    test_async_reset();
    test_ignore_start();
    test_start_stop_idle();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 4, width of the dwell (per-address hold) count.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one scan; sampled only in IDLE.
REQ-005 stop  input  1  abort the current scan; sampled only in SCAN.
REQ-006 down  input  1  0 = ascending 0..15, 1 = descending 15..0; sampled with start.
REQ-007 dwell  input  DWELL_W  extra hold cycles per address; sampled with start.
REQ-008 w  output  4  registered select driven into the downstream 4-to-16 decoder.
REQ-009 En  output  1  registered decoder enable; high only while an address is presented.
REQ-010 busy  output  1  high in SCAN state.
REQ-011 done  output  1  one-cycle pulse on normal scan completion.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE; all outputs SHALL be registered, with no combinational input-to-output path.
REQ-013 IDLE: w=0, En=0, busy=0, done=0.
REQ-014 IDLE with start=1 at edge k: after edge k, state=SCAN, En=1, busy=1, w=0 (down=0) or 15 (down=1), hold counter=dwell (latency 1 cycle).
REQ-015 In SCAN, each address SHALL be presented for exactly dwell+1 cycles; dwell=0 means 1 cycle per address.
REQ-016 When the hold counter reaches 0 and w is not the last address, w SHALL step by +1 (up) or -1 (down) and the counter SHALL reload with the latched dwell.
REQ-017 When the hold counter reaches 0 on the last address (15 up, 0 down), next state SHALL be DONE: En=0, busy=0, w=0, done=1.
REQ-018 DONE SHALL last one cycle and then return to IDLE; done SHALL be high only during DONE.
REQ-019 stop=1 in SCAN SHALL take priority over stepping: next edge goes to IDLE with En=0, busy=0, w=0, and no done pulse.
REQ-020 start SHALL be ignored in SCAN and DONE; stop SHALL be ignored in IDLE and DONE.
REQ-021 start and stop asserted together in IDLE: start SHALL take effect and stop SHALL be ignored.
REQ-022 Changes on down and dwell after the start edge SHALL NOT affect a scan in progress.
REQ-023 w SHALL never take a value outside the current scan's address sequence while En=1.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, w=0, En=0, busy=0, done=0 and the hold counter to 0, independent of clk.
REQ-025 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-026 Macro SCAN_WRAP_EN defined: on the last address the sequence SHALL wrap (15->0 up, 0->15 down) with the normal dwell, never enter DONE, and run until stop or rst.
REQ-027 Macro SCAN_WRAP_EN undefined: the scan SHALL perform a single pass and end through DONE as in REQ-017.

Verification
REQ-028 dwell=0, down=0, one-cycle start pulse -> En=1 for 16 cycles with w=0,1,...,15 (one per cycle); done=1 on cycle 17; busy=0 afterwards.
REQ-029 dwell=2, down=1, start -> each of w=15..0 is held 3 cycles (48 En cycles), then a single done pulse.
REQ-030 dwell=0, stop=1 while w=5 -> next cycle En=0, w=0, busy=0; done stays 0 throughout.
REQ-031 rst asserted between clock edges while w=9 -> En, busy and w clear before the next edge; no done pulse; a later start begins again at w=0.
REQ-032 Mid-scan, start pulse and a change of dwell from 0 to 3 -> scan timing unchanged and no restart; simultaneous start+stop in IDLE -> scan starts.
REQ-033 With SCAN_WRAP_EN defined, dwell=0, down=0 -> w goes 15 then 0 with En continuously 1 and done never asserted; stop then ends the scan.
